// File: rtl/asip_vec_pkg.sv
// Shared types for the ASIP vector datapath.
// Includes the op encoding, default geometry and the default-shaped pipeline stage record.
package asip_vec_pkg;

    localparam int DEF_LANES  = 6;
    localparam int DEF_LW     = 32;
    localparam int DEF_STAGES = 3;
    localparam int DEF_RDW    = 4;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_SLL = 3'b110,
        OP_SRL = 3'b111
    } op_e;

    typedef struct packed {
        logic                            valid;
        logic                            wr;
        logic [DEF_RDW-1:0]              rd;
        logic                            flag_z;
        logic [DEF_LANES*DEF_LW-1:0]     data;
    } stage_t;

endpackage

// File: rtl/vec_lane_alu.sv
// One combinational SIMD lane: computes the op and applies masking / scalar rules.
// zero=1 means this lane does not prevent flagZ (disabled lanes report 1).
module vec_lane_alu
    import asip_vec_pkg::*;
#(
    parameter int LW    = DEF_LW,
    parameter bit LANE0 = 1'b0
) (
    input  logic [2:0]    op,
    input  logic          vec,
    input  logic          en,
    input  logic [LW-1:0] a,
    input  logic [LW-1:0] b,
    output logic [LW-1:0] res,
    output logic          zero
);

    localparam int SHW = (LW > 1) ? $clog2(LW) : 1;

    logic [LW-1:0]  alu;
    logic [SHW-1:0] sh;
    logic           active;

    assign sh     = b[SHW-1:0];
    assign active = vec ? en : LANE0;

    always_comb begin
        alu = '0;
        case (op_e'(op))
            OP_ADD:  alu = a + b;
            OP_SUB:  alu = a - b;
            OP_MUL:  alu = a * b;
            OP_AND:  alu = a & b;
            OP_OR:   alu = a | b;
            OP_XOR:  alu = a ^ b;
            OP_SLL:  alu = a << sh;
            OP_SRL:  alu = a >> sh;
            default: alu = '0;
        endcase
    end

    // Disabled vector lanes pass A through; scalar mode only computes lane 0.
    always_comb begin
        res = '0;
        if (vec) begin
            res = en ? alu : a;
        end else if (LANE0) begin
            res = alu;
        end
    end

    assign zero = ~active | (alu == '0);

endmodule

// File: rtl/vec_exec_pipe.sv
// Pipelined SIMD execution unit: lane ALUs feed STAGES registered stages under a
// global stall, with flush and an in-flight destination-tag hazard query.
module vec_exec_pipe
    import asip_vec_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int LW     = DEF_LW,
    parameter int STAGES = DEF_STAGES,
    parameter int RDW    = DEF_RDW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          op,
    input  logic                vec,
    input  logic [LANES*LW-1:0] a,
    input  logic [LANES*LW-1:0] b,
    input  logic [LANES-1:0]    lane_mask,
    input  logic [RDW-1:0]      rd_in,
    input  logic                wr_in,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LANES*LW-1:0] result,
    output logic                flagZ,
    output logic [RDW-1:0]      rd_out,
    output logic                wr_out,
    input  logic [RDW-1:0]      hz_rd,
    output logic                hazard
);

    // Same layout as the package stage_t, sized by this instance's parameters.
    typedef struct packed {
        logic                valid;
        logic                wr;
        logic [RDW-1:0]      rd;
        logic                flag_z;
        logic [LANES*LW-1:0] data;
    } pipe_stage_t;

    pipe_stage_t         stage_q [STAGES];
    logic [LANES*LW-1:0] lane_res;
    logic [LANES-1:0]    lane_zero;
    logic                lane_flag_z;
    logic                advance;
    logic                accept;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        vec_lane_alu #(
            .LW    (LW),
            .LANE0 (g == 0)
        ) u_alu (
            .op   (op),
            .vec  (vec),
            .en   (lane_mask[g]),
            .a    (a[g*LW +: LW]),
            .b    (b[g*LW +: LW]),
            .res  (lane_res[g*LW +: LW]),
            .zero (lane_zero[g])
        );
    end

    assign lane_flag_z = &lane_zero;
    assign advance     = ~stage_q[STAGES-1].valid | out_ready;
    assign in_ready    = advance;
    assign accept      = in_valid & advance & ~flush;

    // Flush only kills valid bits; data fields may keep stale contents.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i].valid <= 1'b0;
            end
        end else if (advance) begin
            stage_q[0] <= '{valid: accept, wr: wr_in, rd: rd_in,
                            flag_z: lane_flag_z, data: lane_res};
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            if (stage_q[i].valid && stage_q[i].wr && (stage_q[i].rd == hz_rd)) begin
                hazard = 1'b1;
            end
        end
    end

    assign out_valid = stage_q[STAGES-1].valid;
    assign result    = stage_q[STAGES-1].data;
    assign flagZ     = stage_q[STAGES-1].flag_z;
    assign rd_out    = stage_q[STAGES-1].rd;
    assign wr_out    = stage_q[STAGES-1].wr;

endmodule

// File: doc/vec_exec_pipe.md
Name: vec_exec_pipe

Overview:
Parametrised, pipelined SIMD execution unit for the ASIP vector datapath, generalising the fixed 6-lane 192-bit ALU. It accepts LANES x LW operands with a valid/ready handshake, applies a per-lane predicate mask, and delivers results after STAGES cycles. It supports global stall back-pressure and flush. It exposes in-flight destination tags so decode can detect RAW hazards.

Parameters:
LANES, 6, number of SIMD lanes (>=1)
LW, 32, lane width in bits (8..64)
STAGES, 3, pipeline depth = result latency in cycles (>=1)
RDW, 4, destination register tag width

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-low
in_valid  in  1  operand bundle valid
in_ready  out  1  unit can accept this cycle
op  in  3  operation code (see Behaviour)
vec  in  1  1 = vector op, 0 = scalar op (lane 0 only)
a  in  LANES*LW  operand A, lane i = a[i*LW +: LW]
b  in  LANES*LW  operand B, same packing
lane_mask  in  LANES  per-lane enable, vector mode only
rd_in  in  RDW  destination tag carried with the op
wr_in  in  1  op writes a register
flush  in  1  kill all in-flight ops
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  LANES*LW  lane results
flagZ  out  1  all enabled lanes' results are zero
rd_out  out  RDW  tag of the presented result
wr_out  out  1  write flag of the presented result
hz_rd  in  RDW  decode hazard query tag
hazard  out  1  some valid in-flight op with wr=1 has rd == hz_rd

Behaviour:
- Reset (rst=0 at posedge): all stage valid bits = 0. out_valid=0, result=0, flagZ=0, rd_out=0, wr_out=0, hazard=0. in_ready=1 one cycle after reset is released.
- advance = ~out_valid | out_ready. This is a global stall: all stages shift together when advance=1 and hold otherwise. in_ready = advance.
- Accept = in_valid & in_ready & ~flush. Lane computation is combinational before stage 0. Stages 1..STAGES-1 are pure delay. An op accepted at cycle t sets out_valid at cycle t+STAGES when there are no stalls; each stalled cycle adds one.
- Ops, all modulo 2^LW:
  - 000 add
  - 001 sub (a-b)
  - 010 mul, low LW bits
  - 011 and
  - 100 or
  - 101 xor
  - 110 sll
  - 111 srl (logical)
  - Shift amount = b lane low clog2(LW) bits; higher bits are ignored.
- Vector mode, disabled lane: result lane = a lane (pass-through). Disabled lanes are excluded from flagZ.
- Scalar mode: lane 0 is always computed and lane_mask is ignored. Lanes 1..LANES-1 output 0 and are excluded from flagZ.
- flagZ with no enabled lanes (vector, lane_mask=0) = 1.
- flush=1: all valid bits clear at the next edge, including the output stage, regardless of out_ready. Any same-cycle input is dropped. Datapath registers may hold stale values.
- hazard is combinational over all valid stages, including the output stage. Flush takes effect the cycle after assertion.
- When out_valid=1 & out_ready=0, result, flagZ, rd_out and wr_out hold stable.
- Reset mid-stream discards everything; no partial results are emitted.

Decomposition:
- Package asip_vec_pkg: op enum (OP_ADD..OP_SRL), default LANES/LW/STAGES constants, stage record typedef {valid, wr, rd, flagZ, data}.
- Sub-module vec_lane_alu: one combinational LW-bit lane (op, a, b, en, vec/lane-0 select) -> {res, zero}. It is instantiated LANES times via generate.

Test Plan:
- LANES=6, LW=32, STAGES=3. Vector add, a lanes=1..6, b lanes=10, mask=6'h3F, out_ready=1 -> out_valid exactly 3 cycles later, lanes=11..16, flagZ=0.
- Vector sub, a=b=7 all lanes, mask=6'b000101 -> lanes 0 and 2 = 0, other lanes = 7, flagZ=1.
- Scalar mul, a0=32'h0001_0000, b0=32'h0001_0000 -> lane0=0 (wrap), lanes1-5=0, flagZ=1. Scalar srl, a0=32'h8000_0000, b0=33 -> lane0=32'h4000_0000 (amount 1).
- Back-to-back ops A, B, C with out_ready held 0 for 4 cycles after A appears -> in_ready=0 during the hold, A is stable, then A, B, C emerge in order on consecutive cycles with no loss.
- Issue rd=5 wr=1 and set hz_rd=5 -> hazard=1 for cycles t+1..t+3. Then pulse flush at t+2 -> out_valid never rises, hazard=0 from t+3.
- Assert rst=0 for one cycle while 2 ops are in flight -> next cycle out_valid=0, hazard=0, in_ready=1, and no stale result appears afterwards.
